palette_write_ctrl: RTL and testbench

//  Schedules host palette updates into the 512x24 palette RAM write port. Buffers host

---
 rtl/vdp_pkg.sv | 28 ++
 rtl/palette_write_ctrl_if.sv | 47 ++++
 rtl/palette_wr_fifo.sv | 61 ++++++
 rtl/palette_write_ctrl.sv | 144 ++++++++++++++
 tb/tb_palette_write_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_pkg.sv
// ============================================================================
// Module      : vdp_pkg
// Description : Shared palette types and controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vdp_pkg;

    localparam int PALETTE_ENTRIES = 512;

    typedef logic [8:0]  colour_idx_t;
    typedef logic [23:0] rgb_t;

    typedef struct packed {
        colour_idx_t idx;
        rgb_t        rgb;
    } pal_wr_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2
    } pal_state_t;

endpackage : vdp_pkg

`default_nettype wire

// File: rtl/palette_write_ctrl_if.sv
// ============================================================================
// Module      : palette_write_ctrl_if
// Description : Host request, blanking and palette RAM write bundle.
//               PALETTE_AUTOINC_EN adds the req_autoinc request bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface palette_write_ctrl_if
    import vdp_pkg::*;
#(
    parameter int DEPTH = 16
);
    logic                     hblank;
    logic                     vblank;
    logic                     req_valid;
    logic                     req_ready;
    colour_idx_t              req_index;
    rgb_t                     req_rgb;
`ifdef PALETTE_AUTOINC_EN
    logic                     req_autoinc;
`endif
    logic                     pal_we;
    colour_idx_t              pal_waddr;
    rgb_t                     pal_wdata;
    logic [$clog2(DEPTH):0]   level;
    logic                     busy;

    modport master (
        output hblank, vblank, req_valid, req_index, req_rgb,
`ifdef PALETTE_AUTOINC_EN
        output req_autoinc,
`endif
        input  req_ready, pal_we, pal_waddr, pal_wdata, level, busy
    );

    modport slave (
        input  hblank, vblank, req_valid, req_index, req_rgb,
`ifdef PALETTE_AUTOINC_EN
        input  req_autoinc,
`endif
        output req_ready, pal_we, pal_waddr, pal_wdata, level, busy
    );

endinterface : palette_write_ctrl_if

`default_nettype wire

// File: rtl/palette_wr_fifo.sv
// ============================================================================
// Module      : palette_wr_fifo
// Description : Synchronous FIFO of palette writes, wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_wr_fifo
    import vdp_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire pal_wr_t                push_data,
    input  wire logic                   pop,
    output pal_wr_t                     pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int AW = $clog2(DEPTH);

    pal_wr_t       mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty    = (wr_ptr_q == rd_ptr_q);
        level    = wr_ptr_q - rd_ptr_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule : palette_wr_fifo

`default_nettype wire

// File: rtl/palette_write_ctrl.sv
// ============================================================================
// Module      : palette_write_ctrl
// Description : Buffers host palette writes and drains them into the palette
//               RAM write port only during blanking. Option: PALETTE_AUTOINC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_write_ctrl
    import vdp_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int VBLANK_ONLY = 0
) (
    input  wire logic          clk_pix,
    input  wire logic          rst_pix,
    palette_write_ctrl_if.slave bus
);

    localparam int LW = $clog2(DEPTH) + 1;

    pal_state_t    state_q, state_d;
    logic          pal_we_q, pal_we_d;
    colour_idx_t   pal_waddr_q, pal_waddr_d;
    rgb_t          pal_wdata_q, pal_wdata_d;

    logic          blank_ok;
    logic          push, pop, full, empty, last_entry;
    logic [LW-1:0] level;
    pal_wr_t       push_entry, pop_entry;

`ifdef PALETTE_AUTOINC_EN
    colour_idx_t   ptr_q, ptr_d;

    always_comb begin
        ptr_d          = ptr_q;
        push_entry.idx = bus.req_autoinc ? ptr_q : bus.req_index;
        push_entry.rgb = bus.req_rgb;
        if (push) begin
            ptr_d = push_entry.idx + 9'd1;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        push_entry.idx = bus.req_index;
        push_entry.rgb = bus.req_rgb;
    end
`endif

    always_comb begin
        blank_ok   = (VBLANK_ONLY != 0) ? bus.vblank : (bus.hblank | bus.vblank);
        push       = bus.req_valid && !full;
        last_entry = (level == LW'(1)) && !push;
    end

    palette_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_pix),
        .rst       (rst_pix),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // The first pop happens on the ARMED->DRAIN edge so a fresh entry
    // reaches pal_we two edges after it is accepted.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (empty) begin
                    state_d = ST_IDLE;
                end else if (blank_ok) begin
                    pop     = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (empty) begin
                    state_d = ST_IDLE;
                end else if (blank_ok) begin
                    pop = 1'b1;
                    if (last_entry) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pal_we_d    = pop;
        pal_waddr_d = pop ? pop_entry.idx : pal_waddr_q;
        pal_wdata_d = pop ? pop_entry.rgb : pal_wdata_q;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q     <= ST_IDLE;
            pal_we_q    <= 1'b0;
            pal_waddr_q <= '0;
            pal_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            pal_we_q    <= pal_we_d;
            pal_waddr_q <= pal_waddr_d;
            pal_wdata_q <= pal_wdata_d;
        end
    end

    assign bus.req_ready = !full;
    assign bus.level     = level;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.pal_we    = pal_we_q;
    assign bus.pal_waddr = pal_waddr_q;
    assign bus.pal_wdata = pal_wdata_q;

endmodule : palette_write_ctrl

`default_nettype wire

// File: tb/tb_palette_write_ctrl.sv
// ============================================================================
// Module      : tb_palette_write_ctrl
// Description : Directed self-checking bench; dut0 drains on any blank,
//               dut1 on vblank only. PALETTE_AUTOINC_EN enables the autoinc case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_palette_write_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    palette_write_ctrl_if #(.DEPTH(16)) bus0 ();
    palette_write_ctrl_if #(.DEPTH(16)) bus1 ();

    palette_write_ctrl #(.DEPTH(16), .VBLANK_ONLY(0)) dut0 (
        .clk_pix (clk),
        .rst_pix (rst),
        .bus     (bus0.slave)
    );

    palette_write_ctrl #(.DEPTH(16), .VBLANK_ONLY(1)) dut1 (
        .clk_pix (clk),
        .rst_pix (rst),
        .bus     (bus1.slave)
    );

    logic [8:0]  log0_addr[$];
    logic [23:0] log0_data[$];
    int          log0_cyc[$];
    logic [8:0]  log1_addr[$];
    logic [23:0] log1_data[$];

    // pal_we is high for exactly one clock period, so each pulse is seen at one negedge.
    always @(negedge clk) begin
        if (bus0.pal_we === 1'b1) begin
            log0_addr.push_back(bus0.pal_waddr);
            log0_data.push_back(bus0.pal_wdata);
            log0_cyc.push_back(cyc);
        end
        if (bus1.pal_we === 1'b1) begin
            log1_addr.push_back(bus1.pal_waddr);
            log1_data.push_back(bus1.pal_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        log0_addr.delete(); log0_data.delete(); log0_cyc.delete();
        log1_addr.delete(); log1_data.delete();
    endtask

    task automatic push0(input logic [8:0] idx, input logic [23:0] rgb);
        bus0.req_valid = 1'b1;
        bus0.req_index = idx;
        bus0.req_rgb   = rgb;
        tick();
        bus0.req_valid = 1'b0;
    endtask

    task automatic check_log0(input string tag, input int first, input logic [8:0] base,
                              input logic [23:0] rgb_base, input int n);
        for (int i = 0; i < n; i++) begin
            if (first + i < log0_addr.size()) begin
                check({tag, "_addr"}, 32'(log0_addr[first + i]), 32'(base + 9'(i)));
                check({tag, "_data"}, 32'(log0_data[first + i]), 32'(rgb_base | 24'(base + 9'(i))));
            end else begin
                check({tag, "_missing"}, 32'(log0_addr.size()), 32'(first + n));
            end
        end
    endtask

    initial begin
        bus0.hblank = 0; bus0.vblank = 0; bus0.req_valid = 0; bus0.req_index = '0; bus0.req_rgb = '0;
        bus1.hblank = 0; bus1.vblank = 0; bus1.req_valid = 0; bus1.req_index = '0; bus1.req_rgb = '0;
`ifdef PALETTE_AUTOINC_EN
        bus0.req_autoinc = 1'b0;
        bus1.req_autoinc = 1'b0;
`endif
        tick(2);
        check("rst_we",    32'(bus0.pal_we),    32'h0);
        check("rst_waddr", 32'(bus0.pal_waddr), 32'h0);
        check("rst_wdata", 32'(bus0.pal_wdata), 32'h0);
        check("rst_level", 32'(bus0.level),     32'h0);
        check("rst_busy",  32'(bus0.busy),      32'h0);
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(bus0.req_ready), 32'h1);

        // Test 1: fill with blanking low.
        for (int i = 0; i < 16; i++) push0(9'(i), 24'hC00000 | 24'(i));
        check("t1_ready", 32'(bus0.req_ready), 32'h0);
        check("t1_level", 32'(bus0.level),     32'd16);
        check("t1_busy",  32'(bus0.busy),      32'h1);
        push0(9'h0AA, 24'h123456);
        tick(2);
        check("t1_full_level", 32'(bus0.level), 32'd16);
        check("t1_no_we", 32'(log0_addr.size()), 32'd0);

        // Test 2: 20 clocks of hblank drain everything back to back.
        bus0.hblank = 1'b1;
        tick(20);
        bus0.hblank = 1'b0;
        tick();
        check("t2_count", 32'(log0_addr.size()), 32'd16);
        check_log0("t2", 0, 9'd0, 24'hC00000, 16);
        if (log0_cyc.size() == 16)
            check("t2_consec", 32'(log0_cyc[15] - log0_cyc[0]), 32'd15);
        check("t2_level", 32'(bus0.level), 32'd0);
        check("t2_busy",  32'(bus0.busy),  32'h0);
        clear_logs();

        // Test 3: a three-clock blank drains exactly three entries.
        for (int i = 0; i < 8; i++) push0(9'(i), 24'hB00000 | 24'(i));
        bus0.hblank = 1'b1;
        tick(3);
        bus0.hblank = 1'b0;
        tick(3);
        check("t3_count", 32'(log0_addr.size()), 32'd3);
        check_log0("t3a", 0, 9'd0, 24'hB00000, 3);
        check("t3_level", 32'(bus0.level), 32'd5);
        check("t3_busy",  32'(bus0.busy),  32'h1);
        bus0.hblank = 1'b1;
        tick(10);
        bus0.hblank = 1'b0;
        tick();
        check("t3_count2", 32'(log0_addr.size()), 32'd8);
        check_log0("t3b", 3, 9'd3, 24'hB00000, 5);
        check("t3_busy2", 32'(bus0.busy), 32'h0);
        clear_logs();

        // Latency: accepted at edge N with blank already high -> pal_we after N+2.
        bus0.vblank = 1'b1;
        push0(9'h123, 24'h0A0B0C);
        check("lat_n0", 32'(bus0.pal_we), 32'h0);
        tick();
        check("lat_n1", 32'(bus0.pal_we), 32'h0);
        tick();
        check("lat_n2", 32'(bus0.pal_we),    32'h1);
        check("lat_addr", 32'(bus0.pal_waddr), 32'h123);
        check("lat_data", 32'(bus0.pal_wdata), 32'h0A0B0C);
        tick();
        check("lat_pulse", 32'(bus0.pal_we), 32'h0);
        check("lat_hold",  32'(bus0.pal_waddr), 32'h123);
        check("lat_idle",  32'(bus0.busy), 32'h0);
        bus0.vblank = 1'b0;
        tick();
        clear_logs();

        // Test 4: vblank-only variant ignores hblank.
        bus1.req_valid = 1'b1; bus1.req_index = 9'h1FF; bus1.req_rgb = 24'hFF00FF;
        tick();
        bus1.req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus1.hblank = ~bus1.hblank;
            tick();
        end
        bus1.hblank = 1'b0;
        check("t4_no_we", 32'(log1_addr.size()), 32'd0);
        check("t4_level", 32'(bus1.level), 32'd1);
        bus1.vblank = 1'b1;
        tick(4);
        bus1.vblank = 1'b0;
        tick();
        check("t4_count", 32'(log1_addr.size()), 32'd1);
        if (log1_addr.size() > 0) begin
            check("t4_addr", 32'(log1_addr[0]), 32'h1FF);
            check("t4_data", 32'(log1_data[0]), 32'hFF00FF);
        end
        clear_logs();

        // Test 5: push and pop together hold the level, then reset mid-drain.
        for (int i = 0; i < 4; i++) push0(9'h040 + 9'(i), 24'h500000 | 24'(9'h040 + 9'(i)));
        bus0.hblank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus0.req_valid = 1'b1;
            bus0.req_index = 9'h044 + 9'(i);
            bus0.req_rgb   = 24'h500000 | 24'(9'h044 + 9'(i));
            tick();
            check("t5_level", 32'(bus0.level), 32'd4);
        end
        bus0.req_valid = 1'b0;
        tick();
        check("t5_we_pre", 32'(bus0.pal_we), 32'h1);
        check("t5_addr_pre", 32'(bus0.pal_waddr), 32'h048);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_we",    32'(bus0.pal_we), 32'h0);
        check("t5_rst_level", 32'(bus0.level),  32'd0);
        check("t5_rst_busy",  32'(bus0.busy),   32'h0);
        check("t5_order_cnt", 32'(log0_addr.size()), 32'd8);
        check_log0("t5", 0, 9'h040, 24'h500000, 8);
        bus0.hblank = 1'b0;
        tick(2);
        check("t5_rst_hold", 32'(bus0.pal_we), 32'h0);
        #2 rst = 1'b0;
        tick();
        check("t5_ready", 32'(bus0.req_ready), 32'h1);
        clear_logs();

`ifdef PALETTE_AUTOINC_EN
        // Test 6: auto-increment wraps 511 -> 0.
        bus0.req_autoinc = 1'b0;
        push0(9'd510, 24'h600000);
        bus0.req_autoinc = 1'b1;
        for (int i = 1; i < 4; i++) push0(9'h055, 24'h600000 | 24'(i));
        bus0.req_autoinc = 1'b0;
        bus0.vblank = 1'b1;
        tick(10);
        bus0.vblank = 1'b0;
        tick();
        check("t6_count", 32'(log0_addr.size()), 32'd4);
        if (log0_addr.size() == 4) begin
            check("t6_a0", 32'(log0_addr[0]), 32'd510);
            check("t6_a1", 32'(log0_addr[1]), 32'd511);
            check("t6_a2", 32'(log0_addr[2]), 32'd0);
            check("t6_a3", 32'(log0_addr[3]), 32'd1);
            check("t6_d3", 32'(log0_data[3]), 32'h600003);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_palette_write_ctrl

`default_nettype wire
